// File: rtl/stream_buffer_module.sv
// stream_buffer_module: FWFT valid/ready stream buffer with level reporting.
// Optional transfer statistics when STREAM_BUFFER_STATS_EN is defined.
module stream_buffer_module #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stream_in_valid,
    output logic                       stream_in_ready,
    input  logic [DATA_WIDTH-1:0]      stream_in_data,
    output logic                       stream_out_valid,
    input  logic                       stream_out_ready,
    output logic [DATA_WIDTH-1:0]      stream_out_data,
    output logic [$clog2(DEPTH):0]     stream_level,
    output logic                       stream_almost_full
`ifdef STREAM_BUFFER_STATS_EN
    ,
    output logic [31:0]                stream_xfer_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  push;
    logic                  pop;

    assign stream_in_ready    = (level_q != FULL_LVL);
    assign stream_out_valid   = (level_q != '0);
    assign stream_level       = level_q;
    assign stream_almost_full = (level_q >= AF_LVL);

    assign push = stream_in_valid & stream_in_ready;
    assign pop  = stream_out_valid & stream_out_ready;

    // Head word falls through while valid; otherwise the last shown word holds.
    always_comb begin
        stream_out_data = hold_q;
        if (stream_out_valid) begin
            stream_out_data = mem[rd_ptr];
        end
    end

    // Storage write; contents are never reset and a reset edge drops the push.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= stream_in_data;
        end
    end

    // Pointers and occupancy; push+pop together leave the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case (1'b1)
                (push & ~pop): level_q <= level_q + LW'(1);
                (pop & ~push): level_q <= level_q - LW'(1);
                default:       level_q <= level_q;
            endcase
        end
    end

    // Remember the head word so the output holds once the buffer drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (stream_out_valid) begin
            hold_q <= mem[rd_ptr];
        end
    end

`ifdef STREAM_BUFFER_STATS_EN
    // Count output handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stream_xfer_count <= '0;
        end else if (pop) begin
            stream_xfer_count <= stream_xfer_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_buffer_module.sv
// tb_stream_buffer_module: vector table, corner sequences and a
// queue-based reference model under random stimulus.
module tb_stream_buffer_module;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    level;
    logic          almost_full;
`ifdef STREAM_BUFFER_STATS_EN
    logic [31:0]   xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    stream_buffer_module #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ALMOST_FULL(AF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stream_in_valid   (in_valid),
        .stream_in_ready   (in_ready),
        .stream_in_data    (in_data),
        .stream_out_valid  (out_valid),
        .stream_out_ready  (out_ready),
        .stream_out_data   (out_data),
        .stream_level      (level),
        .stream_almost_full(almost_full)
`ifdef STREAM_BUFFER_STATS_EN
        ,
        .stream_xfer_count (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic [2:0]    lvl;
        logic          ir;
        logic          ov;
        logic [DW-1:0] od;
        logic          af;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv,
                         input logic [DW-1:0] d, input logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int            q[$];
    int            last;
    int            xfers;
    int            exp_d;
    logic          m_push;
    logic          m_pop;
    logic          hold_iv;
    logic [DW-1:0] hold_d;

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11, 1'b0};
        vec[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 8'h11, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 8'h11, 1'b1};
        vec[5]  = '{1'b0, 1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b1, 8'h11, 1'b1};
        vec[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 1'b1, 8'h11, 1'b1};
        vec[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 8'h22, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 8'h33, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 8'h44, 1'b0};
        vec[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h44, 1'b0};
        vec[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h44, 1'b0};
        vec[12] = '{1'b0, 1'b1, 8'h66, 1'b1, 3'd1, 1'b1, 1'b1, 8'h66, 1'b0};
        vec[13] = '{1'b1, 1'b1, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 14; i++) begin
            drive(vec[i].rst, vec[i].iv, vec[i].d, vec[i].ordy);
            step();
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vec[i].lvl));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vec[i].ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ov));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vec[i].od));
            chk($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'(vec[i].af));
        end

        // Steady push+pop at level 2 across pointer wrap.
        drive(1'b0, 1'b1, 8'd0, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'd1, 1'b0);
        step();
        chk("wrap_preload_level", 32'(level), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'(i + 2), 1'b1);
            chk($sformatf("wrap_out%0d", i), 32'(out_data), 32'(i));
            step();
            chk($sformatf("wrap_level%0d", i), 32'(level), 32'd2);
        end
        drive(1'b1, 1'b0, 8'd0, 1'b0);
        step();

        // Reset at level 3 with a push pending: word must be lost.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
            step();
        end
        chk("rst_pre_level", 32'(level), 32'd3);
        drive(1'b1, 1'b1, 8'hEE, 1'b0);
        step();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        chk("rst_lost_level", 32'(level), 32'd0);
        chk("rst_lost_valid", 32'(out_valid), 32'd0);

`ifdef STREAM_BUFFER_STATS_EN
        // Seven output handshakes then reset clears the counter.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        chk("stats_seven", xfer_count, 32'd7);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        chk("stats_cleared", xfer_count, 32'd0);
`endif

        // Random stimulus against a queue model.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        q.delete();
        last = 0;
        xfers = 0;
        hold_iv = 1'b0;
        hold_d = '0;
        for (int c = 0; c < 400; c++) begin
            exp_d = (q.size() > 0) ? q[0] : last;
            chk("rnd_level", 32'(level), 32'(q.size()));
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_out_data", 32'(out_data), 32'(exp_d));
            chk("rnd_almost_full", 32'(almost_full), 32'(q.size() >= AF));
`ifdef STREAM_BUFFER_STATS_EN
            chk("rnd_xfer_count", xfer_count, 32'(xfers));
`endif
            if (!hold_iv) begin
                hold_iv = ($urandom_range(0, 2) != 0);
                hold_d  = 8'($urandom);
            end
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = hold_iv;
            in_data   = hold_iv ? hold_d : 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            step();
            if (rst) begin
                q.delete();
                last = 0;
                xfers = 0;
                hold_iv = 1'b0;
            end else begin
                if (q.size() > 0) last = q[0];
                if (m_pop) begin
                    void'(q.pop_front());
                    xfers++;
                end
                if (m_push) begin
                    q.push_back(int'(hold_d));
                    hold_iv = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
